// File: rtl/psum_route_ctrl_pkg.sv
// Shared types and constants for the registered psum route controller.
package psum_route_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } route_state_t;

    localparam int unsigned DEF_ROW_ID_W = 4;
    localparam int unsigned DEF_COL_ID_W = 4;
    localparam int unsigned LAYER_S_W    = 4;

    // A column ID of all-ones marks a PE that takes no part in the layer.
    localparam logic [DEF_COL_ID_W-1:0] COL_ID_UNUSED = '1;

endpackage

// File: rtl/psum_sel_decode.sv
// Combinational per-PE decode of (row ID, column ID, filter height) into psum selects.
module psum_sel_decode
    import psum_route_ctrl_pkg::*;
#(
    parameter int unsigned RID_W = DEF_ROW_ID_W,
    parameter int unsigned CID_W = DEF_COL_ID_W,
    parameter int unsigned S_W   = LAYER_S_W
) (
    input  logic [RID_W-1:0] rid,
    input  logic [CID_W-1:0] cid,
    input  logic [S_W-1:0]   layer_s,
    output logic             en,
    output logic             in_sel,
    output logic             out_sel
);

    localparam int unsigned CMP_W = (RID_W > S_W) ? RID_W : S_W;
    localparam logic [CID_W-1:0] CID_UNUSED = '1;

    logic [CMP_W-1:0] rid_x;
    logic [CMP_W-1:0] s_x;

    assign rid_x = CMP_W'(rid);
    assign s_x   = CMP_W'(layer_s);

    // Row 1 is the bottom of a vertical set, row S is its top.
    assign en      = (rid_x != '0) && (rid_x <= s_x) && (cid != CID_UNUSED);
    assign in_sel  = en && (rid_x == s_x);
    assign out_sel = en && (rid_x == CMP_W'(1));

endmodule

// File: rtl/psum_route_ctrl.sv
// Registered multi-pass psum route controller: latches a layer configuration, holds
// per-PE psum selects stable and counts accumulation passes reported by the PE array.
module psum_route_ctrl
    import psum_route_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ROWS             = 3,
    parameter int unsigned NUM_COLS             = 3,
    parameter int unsigned PSUM_ROW_ID_BITWIDTH = DEF_ROW_ID_W,
    parameter int unsigned PSUM_COL_ID_BITWIDTH = DEF_COL_ID_W,
    parameter int unsigned PASS_CNT_BITWIDTH    = 8
) (
    input  logic                                             i_clk,
    input  logic                                             i_rst_n,
    input  logic                                             i_cfg_valid,
    output logic                                             o_cfg_ready,
    input  logic [LAYER_S_W-1:0]                             i_layer_s,
    input  logic [PASS_CNT_BITWIDTH-1:0]                     i_num_pass,
    input  logic [NUM_ROWS*PSUM_ROW_ID_BITWIDTH-1:0]          i_psum_row_id,
    input  logic [NUM_ROWS*NUM_COLS*PSUM_COL_ID_BITWIDTH-1:0] i_psum_col_id,
    input  logic                                             i_pass_done,
    input  logic                                             i_abort,
    output logic [NUM_ROWS*NUM_COLS-1:0]                     o_psum_in_sel,
    output logic [NUM_ROWS*NUM_COLS-1:0]                     o_psum_gin_sel,
    output logic [NUM_ROWS*NUM_COLS-1:0]                     o_psum_out_sel,
    output logic [NUM_ROWS*NUM_COLS-1:0]                     o_pe_en,
    output logic [PASS_CNT_BITWIDTH-1:0]                     o_pass_idx,
    output logic                                             o_busy,
    output logic                                             o_done,
    output logic                                             o_cfg_err
);

    localparam int unsigned NUM_PE = NUM_ROWS * NUM_COLS;
    localparam int unsigned RID_W  = PSUM_ROW_ID_BITWIDTH;
    localparam int unsigned CID_W  = PSUM_COL_ID_BITWIDTH;

    route_state_t state_q, state_d;

    logic [LAYER_S_W-1:0]         layer_s_q;
    logic [PASS_CNT_BITWIDTH-1:0] num_pass_q;
    logic [NUM_ROWS*RID_W-1:0]    row_id_q;
    logic [NUM_PE*CID_W-1:0]      col_id_q;
    logic                         cfg_latch;

    logic [NUM_PE-1:0] dec_en, dec_in, dec_out;

    logic [NUM_PE-1:0]            en_d, in_d, out_d, gin_d;
    logic [PASS_CNT_BITWIDTH-1:0] pass_d;
    logic                         done_d, err_d;

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
            localparam int unsigned PE = r * NUM_COLS + c;
            psum_sel_decode #(
                .RID_W (RID_W),
                .CID_W (CID_W),
                .S_W   (LAYER_S_W)
            ) u_dec (
                .rid     (row_id_q[r*RID_W +: RID_W]),
                .cid     (col_id_q[PE*CID_W +: CID_W]),
                .layer_s (layer_s_q),
                .en      (dec_en[PE]),
                .in_sel  (dec_in[PE]),
                .out_sel (dec_out[PE])
            );
        end
    end

    always_comb begin
        state_d   = state_q;
        cfg_latch = 1'b0;
        en_d      = o_pe_en;
        in_d      = o_psum_in_sel;
        out_d     = o_psum_out_sel;
        gin_d     = o_psum_gin_sel;
        pass_d    = o_pass_idx;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_cfg_valid) begin
                    if (i_layer_s == '0 || i_num_pass == '0) begin
                        err_d = 1'b1;
                    end else begin
                        cfg_latch = 1'b1;
                        state_d   = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                en_d    = dec_en;
                in_d    = dec_in;
                out_d   = dec_out;
                gin_d   = '0;
                pass_d  = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (i_pass_done) begin
                    if (o_pass_idx == num_pass_q - PASS_CNT_BITWIDTH'(1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        en_d    = '0;
                        in_d    = '0;
                        out_d   = '0;
                        gin_d   = '0;
                        pass_d  = '0;
                    end else begin
                        pass_d = o_pass_idx + PASS_CNT_BITWIDTH'(1);
                        // Later passes accumulate onto the GLB-stored partial sum.
                        gin_d  = o_psum_in_sel & {NUM_PE{pass_d != '0}};
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides every other transition, including a pending handshake.
        if (i_abort) begin
            state_d   = ST_IDLE;
            cfg_latch = 1'b0;
            err_d     = 1'b0;
            done_d    = 1'b0;
            en_d      = '0;
            in_d      = '0;
            out_d     = '0;
            gin_d     = '0;
            pass_d    = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q        <= ST_IDLE;
            layer_s_q      <= '0;
            num_pass_q     <= '0;
            row_id_q       <= '0;
            col_id_q       <= '0;
            o_pe_en        <= '0;
            o_psum_in_sel  <= '0;
            o_psum_out_sel <= '0;
            o_psum_gin_sel <= '0;
            o_pass_idx     <= '0;
            o_done         <= 1'b0;
            o_cfg_err      <= 1'b0;
            o_busy         <= 1'b0;
            o_cfg_ready    <= 1'b1;
        end else begin
            state_q        <= state_d;
            if (cfg_latch) begin
                layer_s_q  <= i_layer_s;
                num_pass_q <= i_num_pass;
                row_id_q   <= i_psum_row_id;
                col_id_q   <= i_psum_col_id;
            end
            o_pe_en        <= en_d;
            o_psum_in_sel  <= in_d;
            o_psum_out_sel <= out_d;
            o_psum_gin_sel <= gin_d;
            o_pass_idx     <= pass_d;
            o_done         <= done_d;
            o_cfg_err      <= err_d;
            o_busy         <= (state_d == ST_LOAD) || (state_d == ST_RUN);
            o_cfg_ready    <= (state_d == ST_IDLE);
        end
    end

endmodule
